// File: rtl/systolic_row_if.sv
// rtl/systolic_row_if.sv - stream, weight-load and result bundle for the systolic row
interface systolic_row_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int COLS   = 4
);
  logic [DATA_W-1:0]      a_in;
  logic                   a_valid;
  logic                   signed_mode;
  logic [DATA_W-1:0]      w_in;
  logic                   w_shift;
  logic                   w_swap;
  logic [COLS*ACC_W-1:0]  acc_in;
  logic                   clear_flags;
  logic [COLS*ACC_W-1:0]  acc_out;
  logic [COLS-1:0]        acc_valid;
  logic [DATA_W-1:0]      a_out;
  logic                   a_valid_out;
  logic [COLS-1:0]        sat_flag;

  modport master (
    output a_in, a_valid, signed_mode, w_in, w_shift, w_swap, acc_in, clear_flags,
    input  acc_out, acc_valid, a_out, a_valid_out, sat_flag
  );

  modport slave (
    input  a_in, a_valid, signed_mode, w_in, w_shift, w_swap, acc_in, clear_flags,
    output acc_out, acc_valid, a_out, a_valid_out, sat_flag
  );
endinterface

// File: rtl/systolic_row.sv
// rtl/systolic_row.sv - weight-stationary MAC row with double-buffered weights and saturation
module systolic_row #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int COLS   = 4
) (
  input  logic         clk,
  input  logic         reset,
  systolic_row_if.slave bus
);

  // Shadow and active weights; shadow chain fills from column 0 toward COLS-1.
  logic [DATA_W-1:0] ws_q [COLS];
  logic [DATA_W-1:0] wa_q [COLS];

  // Per-column stage registers: activation, valid and mode travel together.
  logic [DATA_W-1:0] a_q   [COLS];
  logic [COLS-1:0]   v_q;
  logic [COLS-1:0]   m_q;
  logic [ACC_W-1:0]  acc_q [COLS];
  logic [COLS-1:0]   accv_q;
  logic [COLS-1:0]   sat_q;

  // Stage inputs and arithmetic results.
  logic [DATA_W-1:0]   st_a  [COLS];
  logic [COLS-1:0]     st_v;
  logic [COLS-1:0]     st_m;
  logic [2*DATA_W-1:0] prod  [COLS];
  logic [ACC_W:0]      sum   [COLS];
  logic [ACC_W-1:0]    acc_d [COLS];
  logic [COLS-1:0]     sat_hit;

  // Column 0 reads the ports; later columns read the previous stage register.
  always_comb begin
    st_v = '0;
    st_m = '0;
    for (int k = 0; k < COLS; k++) begin
      st_a[k] = '0;
    end
    st_a[0] = bus.a_in;
    st_v[0] = bus.a_valid;
    st_m[0] = bus.signed_mode;
    for (int k = 1; k < COLS; k++) begin
      st_a[k] = a_q[k-1];
      st_v[k] = v_q[k-1];
      st_m[k] = m_q[k-1];
    end
  end

  // Multiply-accumulate in ACC_W+1 bits, then clamp; mode picks sign or zero extension.
  always_comb begin
    sat_hit = '0;
    for (int k = 0; k < COLS; k++) begin
      prod[k]  = {{DATA_W{st_m[k] & st_a[k][DATA_W-1]}}, st_a[k]}
               * {{DATA_W{st_m[k] & wa_q[k][DATA_W-1]}}, wa_q[k]};
      sum[k]   = {{(ACC_W+1-2*DATA_W){st_m[k] & prod[k][2*DATA_W-1]}}, prod[k]}
               + {st_m[k] & bus.acc_in[k*ACC_W + ACC_W-1], bus.acc_in[k*ACC_W +: ACC_W]};
      acc_d[k] = sum[k][ACC_W-1:0];
      if (st_m[k]) begin
        sat_hit[k] = sum[k][ACC_W] ^ sum[k][ACC_W-1];
        if (sat_hit[k]) begin
          acc_d[k] = sum[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
      end else begin
        sat_hit[k] = sum[k][ACC_W];
        if (sat_hit[k]) begin
          acc_d[k] = '1;
        end
      end
    end
  end

  // Stage advance: data registers hold on bubbles, valids follow the stage input every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < COLS; k++) begin
        a_q[k]   <= '0;
        acc_q[k] <= '0;
      end
      v_q    <= '0;
      m_q    <= '0;
      accv_q <= '0;
      sat_q  <= '0;
    end else begin
      for (int k = 0; k < COLS; k++) begin
        if (st_v[k]) begin
          a_q[k]   <= st_a[k];
          acc_q[k] <= acc_d[k];
        end
      end
      v_q    <= st_v;
      accv_q <= st_v;
      m_q    <= (m_q & ~st_v) | (st_m & st_v);
      // A saturation on the same edge as clear_flags leaves the flag set.
      sat_q  <= (bus.clear_flags ? '0 : sat_q) | (st_v & sat_hit);
    end
  end

  // Weight double buffer: swap samples the pre-shift shadow values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < COLS; k++) begin
        ws_q[k] <= '0;
        wa_q[k] <= '0;
      end
    end else begin
      if (bus.w_shift) begin
        ws_q[0] <= bus.w_in;
        for (int k = 1; k < COLS; k++) begin
          ws_q[k] <= ws_q[k-1];
        end
      end
      if (bus.w_swap) begin
        for (int k = 0; k < COLS; k++) begin
          wa_q[k] <= ws_q[k];
        end
      end
    end
  end

  for (genvar g = 0; g < COLS; g++) begin : g_out
    assign bus.acc_out[g*ACC_W +: ACC_W] = acc_q[g];
  end

  assign bus.acc_valid   = accv_q;
  assign bus.a_out       = a_q[COLS-1];
  assign bus.a_valid_out = v_q[COLS-1];
  assign bus.sat_flag    = sat_q;

endmodule

// File: tb/tb_systolic_row.sv
// tb/tb_systolic_row.sv - directed self-checking bench for systolic_row
module tb_systolic_row;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NC = 4;

  logic clk;
  logic reset;
  int checks;
  int failures;

  systolic_row_if #(.DATA_W(DW), .ACC_W(AW), .COLS(NC)) bus ();

  systolic_row #(.DATA_W(DW), .ACC_W(AW), .COLS(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] col(input int k);
    return bus.acc_out[k*AW +: AW];
  endfunction

  // Shift four words (first ends in column NC-1), then commit with a separate swap edge.
  task automatic load_w(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] ws [4];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    for (int i = 0; i < 4; i++) begin
      bus.w_in = ws[i];
      bus.w_shift = 1'b1;
      tick();
    end
    bus.w_shift = 1'b0;
    bus.w_swap = 1'b1;
    tick();
    bus.w_swap = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.a_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int old_w [4];
  int new_w [4];
  int j;
  logic [AW-1:0] expv;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.a_in = '0; bus.a_valid = 1'b0; bus.signed_mode = 1'b0;
    bus.w_in = '0; bus.w_shift = 1'b0; bus.w_swap = 1'b0;
    bus.acc_in = '0; bus.clear_flags = 1'b0;
    tick(); tick();
    chk("rst_acc_out", bus.acc_out, 0);
    chk("rst_acc_valid", bus.acc_valid, 0);
    chk("rst_avo", bus.a_valid_out, 0);
    reset = 1'b0;

    // Reset mid-stream clears everything immediately.
    load_w(16'd1, 16'd2, 16'd3, 16'd4);
    bus.acc_in = {4{32'd10}};
    bus.a_in = 16'd7; bus.a_valid = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_acc_out", bus.acc_out, 0);
    chk("midrst_acc_valid", bus.acc_valid, 0);
    chk("midrst_a_out", {bus.a_valid_out, bus.a_out}, 0);
    chk("midrst_sat", bus.sat_flag, 0);
    bus.a_valid = 1'b0;
    #1;
    reset = 1'b0;
    tick(); tick(); tick();
    chk("postrst_no_valid", {bus.acc_valid, bus.a_valid_out}, 0);

    // Basic MAC: wa = 4,3,2,1 for columns 0..3, a=5, acc_in=10.
    load_w(16'd1, 16'd2, 16'd3, 16'd4);
    bus.acc_in = {4{32'd10}};
    bus.a_in = 16'd5; bus.a_valid = 1'b1; bus.signed_mode = 1'b0;
    tick();
    bus.a_valid = 1'b0;
    chk("mac_v0", bus.acc_valid, 4'b0001);
    chk("mac_c0", col(0), 30);
    tick();
    chk("mac_v1", bus.acc_valid, 4'b0010);
    chk("mac_c1", col(1), 25);
    tick();
    chk("mac_v2", bus.acc_valid, 4'b0100);
    chk("mac_c2", col(2), 20);
    tick();
    chk("mac_v3", bus.acc_valid, 4'b1000);
    chk("mac_c3", col(3), 15);
    chk("mac_aout", {bus.a_valid_out, bus.a_out}, {1'b1, 16'd5});
    tick();
    chk("mac_v_end", {bus.acc_valid, bus.a_valid_out}, 0);
    chk("mac_hold_c0", col(0), 30);

    // Double buffer: 8 back-to-back activations, shift new set on edges 1..4, swap on edge 5.
    old_w[0] = 4;  old_w[1] = 3;  old_w[2] = 2;  old_w[3] = 1;
    new_w[0] = 40; new_w[1] = 30; new_w[2] = 20; new_w[3] = 10;
    bus.acc_in = '0;
    for (int c = 1; c <= 11; c++) begin
      bus.a_valid = (c <= 8);
      bus.a_in = 16'(c);
      bus.w_shift = (c <= 4);
      bus.w_in = 16'(10 * c);
      bus.w_swap = (c == 5);
      tick();
      for (int k = 0; k < NC; k++) begin
        j = c - k;
        if (j >= 1 && j <= 8) begin
          expv = 32'(j * ((j + k <= 5) ? old_w[k] : new_w[k]));
          chk($sformatf("dbuf_v_c%0d_k%0d", c, k), bus.acc_valid[k], 1'b1);
          chk($sformatf("dbuf_c%0d_k%0d", c, k), col(k), expv);
        end
      end
    end
    bus.w_shift = 1'b0; bus.w_swap = 1'b0;
    idle(2);

    // Signed saturation on column 0.
    load_w(16'd1, 16'd1, 16'd1, 16'h8000);
    bus.acc_in = {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF};
    bus.a_in = 16'h8000; bus.signed_mode = 1'b1; bus.a_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0;
    chk("ssat_c0", col(0), 32'h7FFFFFFF);
    chk("ssat_flag0", bus.sat_flag, 4'b0001);
    tick(); tick(); tick();
    chk("ssat_c3", col(3), 32'hFFFF8000);
    chk("ssat_flags", bus.sat_flag, 4'b0001);
    bus.clear_flags = 1'b1;
    tick();
    bus.clear_flags = 1'b0;
    chk("ssat_clear", bus.sat_flag, 0);
    bus.clear_flags = 1'b1; bus.a_valid = 1'b1;
    tick();
    bus.clear_flags = 1'b0; bus.a_valid = 1'b0;
    chk("ssat_set_wins", bus.sat_flag, 4'b0001);
    idle(4);
    bus.clear_flags = 1'b1;
    tick();
    bus.clear_flags = 1'b0;

    // Unsigned saturation, then signed -1 * -1.
    load_w(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    bus.acc_in = {4{32'hFFFFFFFF}};
    bus.a_in = 16'hFFFF; bus.signed_mode = 1'b0; bus.a_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0;
    chk("usat_c0", col(0), 32'hFFFFFFFF);
    chk("usat_flag0", bus.sat_flag, 4'b0001);
    tick(); tick(); tick();
    chk("usat_c3", col(3), 32'hFFFFFFFF);
    chk("usat_flags", bus.sat_flag, 4'b1111);
    bus.clear_flags = 1'b1;
    tick();
    bus.clear_flags = 1'b0;
    bus.acc_in = '0;
    bus.signed_mode = 1'b1; bus.a_valid = 1'b1;
    tick();
    bus.a_valid = 1'b0;
    chk("sneg_c0", col(0), 32'd1);
    tick(); tick(); tick();
    chk("sneg_c3", col(3), 32'd1);
    chk("sneg_flags", bus.sat_flag, 0);

    // Mode pipelining: signed_mode alternates per activation, a=0xFFFF, w=2.
    load_w(16'd2, 16'd2, 16'd2, 16'd2);
    bus.acc_in = '0;
    for (int c = 1; c <= 9; c++) begin
      bus.a_valid = (c <= 6);
      bus.signed_mode = c[0];
      bus.a_in = 16'hFFFF;
      tick();
      for (int k = 0; k < NC; k++) begin
        j = c - k;
        if (j >= 1 && j <= 6) begin
          expv = j[0] ? 32'hFFFFFFFE : 32'h0001FFFE;
          chk($sformatf("mode_c%0d_k%0d", c, k), col(k), expv);
        end
      end
    end
    bus.a_valid = 1'b0;
    chk("mode_flags", bus.sat_flag, 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
